// File: rtl/mmio_io_bridge.sv
// rtl/mmio_io_bridge.sv - memory-mapped I/O stage: HEX/LED/switch/counter registers and sticky halt
module mmio_io_bridge #(
  parameter int CNT_W = 32
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] DataAddr,
  input  logic        WriteEn,
  input  logic [15:0] WriteValue,
  input  logic        ReadEn,
  output logic [15:0] ReadValue,
  output logic        ReadValid,
  output logic        IoHit,
  output logic        Halt,
  input  logic [9:0]  SW,
  output logic [9:0]  LEDR,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);

  // Word offsets inside the 0xFFF0..0xFFFF window
  localparam logic [3:0] A_HEX_LO = 4'h0;
  localparam logic [3:0] A_HEX_HI = 4'h1;
  localparam logic [3:0] A_LED    = 4'h2;
  localparam logic [3:0] A_SWITCH = 4'h3;
  localparam logic [3:0] A_CNT_LO = 4'h4;
  localparam logic [3:0] A_CNT_HI = 4'h5;
  localparam logic [3:0] A_HEX_EN = 4'h6;
  localparam logic [3:0] A_KILL   = 4'hF;

  logic [15:0]      hex_lo_q, hex_lo_d;
  logic [7:0]       hex_hi_q, hex_hi_d;
  logic [9:0]       led_q, led_d;
  logic [5:0]       hex_en_q, hex_en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [9:0]       sw_meta_q, sw_meta_d;
  logic [9:0]       sw_sync_q, sw_sync_d;
  logic             halt_q, halt_d;
  logic [15:0]      read_value_q, read_value_d;
  logic             read_valid_q, read_valid_d;

  logic        rd_acc;
  logic        wr_acc;
  logic [3:0]  offs;
  logic [31:0] cnt_view;
  logic [15:0] read_data;

  assign IoHit    = (DataAddr[15:4] == 12'hFFF);
  assign offs     = DataAddr[3:0];
  assign rd_acc   = ReadEn & IoHit;
  // Once halted, every store (including another KILL) is dropped
  assign wr_acc   = WriteEn & IoHit & ~halt_q;
  assign cnt_view = 32'(cnt_q);

  // Active-low seven-segment glyph for one nibble, blanked when disabled
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib, input logic en);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return en ? g : 7'h7F;
  endfunction

  // Load data mux; unmapped offsets (and KILL) read as zero
  always_comb begin
    read_data = 16'h0000;
    case (offs)
      A_HEX_LO: read_data = hex_lo_q;
      A_HEX_HI: read_data = {8'h00, hex_hi_q};
      A_LED:    read_data = {6'h00, led_q};
      A_SWITCH: read_data = {6'h00, sw_sync_q};
      A_CNT_LO: read_data = cnt_view[15:0];
      A_CNT_HI: read_data = shadow_q;
      A_HEX_EN: read_data = {10'h000, hex_en_q};
      default:  read_data = 16'h0000;
    endcase
  end

  // Next-state: stores, counter, CNT_LO snapshot, switch synchronizer, read response
  always_comb begin
    hex_lo_d     = hex_lo_q;
    hex_hi_d     = hex_hi_q;
    led_d        = led_q;
    hex_en_d     = hex_en_q;
    halt_d       = halt_q;
    shadow_d     = shadow_q;
    read_value_d = read_value_q;
    read_valid_d = rd_acc;
    sw_meta_d    = SW;
    sw_sync_d    = sw_meta_q;
    // The KILL edge itself still counts, so the value loaded on that edge is final
    cnt_d        = halt_q ? cnt_q : cnt_q + CNT_W'(1);

    if (wr_acc) begin
      case (offs)
        A_HEX_LO: hex_lo_d = WriteValue;
        A_HEX_HI: hex_hi_d = WriteValue[7:0];
        A_LED:    led_d    = WriteValue[9:0];
        A_HEX_EN: hex_en_d = WriteValue[5:0];
        A_KILL:   halt_d   = 1'b1;
        default:  ;
      endcase
    end

    if (rd_acc) begin
      // Reads see pre-write state, so a same-cycle load/store returns the old value
      read_value_d = read_data;
      // Snapshot the high half from the same pre-increment count the low half came from
      if (offs == A_CNT_LO) shadow_d = cnt_view[31:16];
    end
  end

  // State registers; reset wins over any simultaneous access
  always_ff @(posedge Clock) begin
    if (Reset) begin
      hex_lo_q     <= '0;
      hex_hi_q     <= '0;
      led_q        <= '0;
      hex_en_q     <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      halt_q       <= 1'b0;
      read_value_q <= '0;
      read_valid_q <= 1'b0;
    end else begin
      hex_lo_q     <= hex_lo_d;
      hex_hi_q     <= hex_hi_d;
      led_q        <= led_d;
      hex_en_q     <= hex_en_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      sw_meta_q    <= sw_meta_d;
      sw_sync_q    <= sw_sync_d;
      halt_q       <= halt_d;
      read_value_q <= read_value_d;
      read_valid_q <= read_valid_d;
    end
  end

  assign ReadValue = read_value_q;
  assign ReadValid = read_valid_q;
  assign Halt      = halt_q;
  assign LEDR      = led_q;
  assign HEX0      = hex_glyph(hex_lo_q[3:0],   hex_en_q[0]);
  assign HEX1      = hex_glyph(hex_lo_q[7:4],   hex_en_q[1]);
  assign HEX2      = hex_glyph(hex_lo_q[11:8],  hex_en_q[2]);
  assign HEX3      = hex_glyph(hex_lo_q[15:12], hex_en_q[3]);
  assign HEX4      = hex_glyph(hex_hi_q[3:0],   hex_en_q[4]);
  assign HEX5      = hex_glyph(hex_hi_q[7:4],   hex_en_q[5]);

endmodule

// File: tb/tb_mmio_io_bridge.sv
// tb/tb_mmio_io_bridge.sv - self-checking bench for mmio_io_bridge
module tb_mmio_io_bridge;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] DataAddr;
  logic        WriteEn;
  logic [15:0] WriteValue;
  logic        ReadEn;
  logic [15:0] ReadValue;
  logic        ReadValid;
  logic        IoHit;
  logic        Halt;
  logic [9:0]  SW;
  logic [9:0]  LEDR;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [6:0]  hex_out [6];

  int n_checks = 0;
  int n_pass   = 0;

  mmio_io_bridge #(.CNT_W(32)) dut (
    .Clock(Clock), .Reset(Reset), .DataAddr(DataAddr), .WriteEn(WriteEn),
    .WriteValue(WriteValue), .ReadEn(ReadEn), .ReadValue(ReadValue),
    .ReadValid(ReadValid), .IoHit(IoHit), .Halt(Halt), .SW(SW), .LEDR(LEDR),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  always #5 Clock = ~Clock;

  assign hex_out[0] = HEX0;
  assign hex_out[1] = HEX1;
  assign hex_out[2] = HEX2;
  assign hex_out[3] = HEX3;
  assign hex_out[4] = HEX4;
  assign hex_out[5] = HEX5;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Reference model: register file indexed by word offset, plain integer counter
  logic [15:0] m_reg [16];
  logic [31:0] m_cnt;
  logic [15:0] m_shadow;
  logic        m_halt;
  logic [15:0] m_rv;
  logic        m_rvalid;
  logic [9:0]  m_sw0, m_sw1;

  function automatic logic [15:0] wmask(input logic [3:0] a);
    case (a)
      4'h0: return 16'hFFFF;
      4'h1: return 16'h00FF;
      4'h2: return 16'h03FF;
      4'h6: return 16'h003F;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] m_read(input logic [3:0] a);
    case (a)
      4'h0, 4'h1, 4'h2, 4'h6: return m_reg[a];
      4'h3: return {6'h00, m_sw1};
      4'h4: return m_cnt[15:0];
      4'h5: return m_shadow;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [6:0] exp_hex(input int k);
    logic [23:0] disp;
    int d;
    disp = {m_reg[1][7:0], m_reg[0]};
    d = int'((disp >> (4 * k)) & 24'hF);
    if (!m_reg[6][k]) return 7'h7F;
    return GLYPH[d];
  endfunction

  // Model advances on the same edge as the DUT
  always @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) m_reg[i] <= 16'h0;
      m_cnt <= 32'h0; m_shadow <= 16'h0; m_halt <= 1'b0;
      m_rv <= 16'h0; m_rvalid <= 1'b0; m_sw0 <= 10'h0; m_sw1 <= 10'h0;
    end else begin
      m_sw0 <= SW;
      m_sw1 <= m_sw0;
      if (!m_halt) m_cnt <= m_cnt + 32'd1;
      m_rvalid <= ReadEn && (DataAddr[15:4] == 12'hFFF);
      if (ReadEn && DataAddr[15:4] == 12'hFFF) begin
        m_rv <= m_read(DataAddr[3:0]);
        if (DataAddr[3:0] == 4'h4) m_shadow <= m_cnt[31:16];
      end
      if (WriteEn && DataAddr[15:4] == 12'hFFF && !m_halt) begin
        if (DataAddr[3:0] == 4'hF) m_halt <= 1'b1;
        else m_reg[DataAddr[3:0]] <= WriteValue & wmask(DataAddr[3:0]);
      end
    end
  end

  task automatic idle_inputs();
    WriteEn = 1'b0; ReadEn = 1'b0; DataAddr = 16'h0000; WriteValue = 16'h0000;
  endtask

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic drive_write(input logic [15:0] a, input logic [15:0] v);
    DataAddr = a; WriteValue = v; WriteEn = 1'b1; ReadEn = 1'b0;
    tick();
    idle_inputs();
  endtask

  task automatic drive_read(input logic [15:0] a);
    DataAddr = a; ReadEn = 1'b1; WriteEn = 1'b0;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    n_checks++; if (LEDR !== 10'h000) $display("FAIL reset_ledr got=%h exp=000", LEDR); else n_pass++;
    n_checks++; if (Halt !== 1'b0) $display("FAIL reset_halt got=%b exp=0", Halt); else n_pass++;
    n_checks++; if (ReadValid !== 1'b0) $display("FAIL reset_rvalid got=%b exp=0", ReadValid); else n_pass++;
    n_checks++; if (ReadValue !== 16'h0000) $display("FAIL reset_rvalue got=%h exp=0000", ReadValue); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (hex_out[k] !== 7'h7F) $display("FAIL reset_hex%0d got=%h exp=7f", k, hex_out[k]); else n_pass++;
    end
    tick();
    drive_read(16'hFFF4);
    n_checks++; if (ReadValid !== 1'b1) $display("FAIL reset_cnt_valid got=%b exp=1", ReadValid); else n_pass++;
    n_checks++; if (ReadValue !== m_rv || ReadValue > 16'd4)
      $display("FAIL reset_cnt_lo got=%h exp=%h", ReadValue, m_rv); else n_pass++;
  endtask

  task automatic test_hex_led();
    drive_write(16'hFFF6, 16'h0001);
    drive_write(16'hFFF0, 16'h00AF);
    drive_write(16'hFFF2, 16'h03FF);
    n_checks++; if (HEX0 !== 7'h0E) $display("FAIL hexled_hex0 got=%h exp=0e", HEX0); else n_pass++;
    for (int k = 1; k < 6; k++) begin
      n_checks++;
      if (hex_out[k] !== 7'h7F) $display("FAIL hexled_hex%0d got=%h exp=7f", k, hex_out[k]); else n_pass++;
    end
    n_checks++; if (LEDR !== 10'h3FF) $display("FAIL hexled_ledr got=%h exp=3ff", LEDR); else n_pass++;
    drive_read(16'hFFF2);
    n_checks++; if (ReadValid !== 1'b1 || ReadValue !== 16'h03FF)
      $display("FAIL hexled_read got=%b/%h exp=1/03ff", ReadValid, ReadValue); else n_pass++;
    tick();
    n_checks++; if (ReadValid !== 1'b0) $display("FAIL hexled_pulse got=%b exp=0", ReadValid); else n_pass++;
  endtask

  task automatic test_switch();
    SW = 10'h2A5;
    tick(); tick(); tick();
    drive_read(16'hFFF3);
    n_checks++; if (ReadValue !== 16'h02A5) $display("FAIL switch_read got=%h exp=02a5", ReadValue); else n_pass++;
    drive_write(16'hFFF3, 16'h1234);
    drive_read(16'hFFF3);
    n_checks++; if (ReadValue !== 16'h02A5) $display("FAIL switch_reread got=%h exp=02a5", ReadValue); else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] a;
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(9) == 0) a = 16'($urandom_range(16'hFFEF));
      else a = {12'hFFF, 4'($urandom_range(15))};
      DataAddr = a;
      ReadEn = 1'($urandom_range(1));
      WriteEn = (a[3:0] == 4'hF) ? 1'b0 : 1'($urandom_range(1));
      WriteValue = 16'($urandom);
      if ($urandom_range(7) == 0) SW = 10'($urandom);
      #1;
      n_checks++; if (IoHit !== (a[15:4] == 12'hFFF))
        $display("FAIL rand_iohit addr=%h got=%b", a, IoHit); else n_pass++;
      tick();
      n_checks++; if (ReadValid !== m_rvalid)
        $display("FAIL rand_rvalid it=%0d got=%b exp=%b", it, ReadValid, m_rvalid); else n_pass++;
      if (m_rvalid) begin
        n_checks++; if (ReadValue !== m_rv)
          $display("FAIL rand_rvalue it=%0d got=%h exp=%h", it, ReadValue, m_rv); else n_pass++;
      end
      n_checks++; if (LEDR !== m_reg[2][9:0])
        $display("FAIL rand_ledr it=%0d got=%h exp=%h", it, LEDR, m_reg[2][9:0]); else n_pass++;
      for (int k = 0; k < 6; k++) begin
        n_checks++; if (hex_out[k] !== exp_hex(k))
          $display("FAIL rand_hex%0d it=%0d got=%h exp=%h", k, it, hex_out[k], exp_hex(k)); else n_pass++;
      end
      n_checks++; if (Halt !== 1'b0) $display("FAIL rand_halt it=%0d got=%b exp=0", it, Halt); else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 40; it++) begin
      DataAddr = {12'hFFF, 4'($urandom_range(7))};
      ReadEn = 1'b1;
      tick();
      n_checks++; if (ReadValid !== 1'b1 || ReadValue !== m_rv)
        $display("FAIL b2b it=%0d got=%b/%h exp=1/%h", it, ReadValid, ReadValue, m_rv); else n_pass++;
    end
    idle_inputs();
    tick();
    n_checks++; if (ReadValid !== 1'b0) $display("FAIL b2b_end got=%b exp=0", ReadValid); else n_pass++;
  endtask

  task automatic test_counter_carry();
    int waited;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    waited = 0;
    while (m_cnt != 32'h0000FFFF && waited < 70000) begin
      tick();
      waited++;
    end
    n_checks++; if (m_cnt != 32'h0000FFFF) $display("FAIL carry_timeout got=%h exp=0000ffff", m_cnt); else n_pass++;
    drive_read(16'hFFF4);
    n_checks++; if (ReadValue !== 16'hFFFF) $display("FAIL carry_lo got=%h exp=ffff", ReadValue); else n_pass++;
    drive_read(16'hFFF5);
    n_checks++; if (ReadValue !== 16'h0000) $display("FAIL carry_hi got=%h exp=0000", ReadValue); else n_pass++;
    drive_read(16'hFFF4);
    drive_read(16'hFFF5);
    n_checks++; if (ReadValue !== 16'h0001) $display("FAIL carry_live_hi got=%h exp=0001", ReadValue); else n_pass++;
  endtask

  task automatic test_kill();
    logic [9:0]  led_before;
    logic [15:0] r1;
    drive_write(16'hFFF2, 16'h0155);
    drive_write(16'hFFFF, 16'hBEEF);
    n_checks++; if (Halt !== 1'b1) $display("FAIL kill_halt got=%b exp=1", Halt); else n_pass++;
    led_before = LEDR;
    drive_write(16'hFFF2, 16'h00FF);
    n_checks++; if (LEDR !== 10'h155 || LEDR !== led_before)
      $display("FAIL kill_ledr got=%h exp=155", LEDR); else n_pass++;
    drive_read(16'hFFF4);
    r1 = ReadValue;
    repeat (10) tick();
    drive_read(16'hFFF4);
    n_checks++; if (ReadValid !== 1'b1 || ReadValue !== r1 || ReadValue !== m_rv)
      $display("FAIL kill_cnt_frozen got=%h exp=%h", ReadValue, r1); else n_pass++;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_checks++; if (Halt !== 1'b0) $display("FAIL kill_reset got=%b exp=0", Halt); else n_pass++;
  endtask

  task automatic test_simultaneous_and_range();
    drive_write(16'hFFF2, 16'h0003);
    DataAddr = 16'hFFF2; ReadEn = 1'b1; WriteEn = 1'b1; WriteValue = 16'h0005;
    tick();
    idle_inputs();
    n_checks++; if (ReadValue !== 16'h0003) $display("FAIL simul_read got=%h exp=0003", ReadValue); else n_pass++;
    n_checks++; if (LEDR !== 10'h005) $display("FAIL simul_ledr got=%h exp=005", LEDR); else n_pass++;
    DataAddr = 16'h1000; ReadEn = 1'b1;
    #1;
    n_checks++; if (IoHit !== 1'b0) $display("FAIL range_iohit got=%b exp=0", IoHit); else n_pass++;
    tick();
    idle_inputs();
    n_checks++; if (ReadValid !== 1'b0) $display("FAIL range_rvalid got=%b exp=0", ReadValid); else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    drive_write(16'hFFF6, 16'h003F);
    DataAddr = 16'hFFF2; ReadEn = 1'b1; Reset = 1'b1;
    tick();
    Reset = 1'b0;
    idle_inputs();
    n_checks++; if (ReadValid !== 1'b0) $display("FAIL midrst_rvalid got=%b exp=0", ReadValid); else n_pass++;
    n_checks++; if (LEDR !== 10'h000) $display("FAIL midrst_ledr got=%h exp=000", LEDR); else n_pass++;
    n_checks++; if (HEX5 !== 7'h7F) $display("FAIL midrst_hex5 got=%h exp=7f", HEX5); else n_pass++;
  endtask

  initial begin
    Reset = 1'b1;
    SW = 10'h000;
    idle_inputs();
    tick();
    test_reset();
    test_hex_led();
    test_switch();
    test_random();
    test_back_to_back();
    test_simultaneous_and_range();
    test_counter_carry();
    test_kill();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
